mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the single unified instruction/data memory of the multi-cycle RISC-V core. It shares the memory port between the core (fetch, load and store accesses) and a debug/program-loader port. Memory may be variable-latency: the arbiter issues one transaction at a time, holds it until acknowledged or timed out, and returns completion and read data to the owning requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max BUSY cycles without m_ack before abort (≥2)
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- c_req / d_req  in  1  core / debug request; held with fields stable until gnt
- c_we / d_we  in  1  1 = write
- c_addr / d_addr  in  ADDR_W  byte address
- c_wdata / d_wdata  in  DATA_W  write data
- c_gnt / d_gnt  out  1  combinational accept pulse
- c_rvalid / d_rvalid  out  1  registered completion pulse
- c_rdata / d_rdata  out  DATA_W  read data, valid with rvalid
- c_err / d_err  out  1  timeout flag, valid with rvalid
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ack  in  1  memory completion; m_rdata is valid in the same cycle
- m_rdata  in  DATA_W  memory read data
- busy  out  1  high in BUSY

## Operation
- FSM has two states: IDLE and BUSY. Reset puts the FSM in IDLE.
- **IDLE, no req:** hold.
- **IDLE, one req:** assert that port's gnt, latch we/addr/wdata/owner, and go to BUSY.
- **IDLE, both req:** round-robin. Grant the port not granted last; last_gnt updates on every grant.
- **BUSY:**
  - m_req=1 and m_we/m_addr/m_wdata come from the latched registers. Requester inputs and new reqs are ignored; gnt stays low.
  - On m_ack: m_req drops the next cycle, owner rvalid=1 the next cycle, and the FSM returns to IDLE.
  - For a read, rdata takes m_rdata. For a write, rdata = 0.
- **Timeout:**
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle without m_ack.
  - On the TIMEOUT-th such cycle: abort, go to IDLE, owner rvalid=1 and err=1 the next cycle, rdata = 0.
  - m_ack in the timeout cycle wins: normal completion, err=0.
- m_ack in IDLE is ignored.
- rdata/err hold their values until the next rvalid to the same port.
- Requester may re-raise req immediately after gnt; it is accepted only after the current completion.

## Timing
- **Reset values:**
  - All outputs are 0 (m_req, m_we, m_addr, m_wdata, gnt, rvalid, rdata, err, busy).
  - last_gnt = debug, so the core wins the first contention.
  - Counter = 0.
- **Minimum latency:** req accepted at T (gnt at T), m_req at T+1. m_ack at T+1 gives rvalid at T+2, IDLE at T+2, and the next gnt possible at T+2.
- **Throughput:** one transaction per 2 cycles at zero-wait memory.
- **Timeout:** with no ack, m_req is high T+1…T+TIMEOUT, and rvalid+err come at T+TIMEOUT+1.
- **Reset mid-transaction:**
  - m_req drops asynchronously.
  - No rvalid is generated for the lost transaction.
  - Reset values apply.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the owner ids (PORT_CORE=0, PORT_DBG=1);
  - the default TIMEOUT constant.
- One sub-module: arb_timeout_cnt. It contains the clear/enable/expire counter, parameterised by TIMEOUT.

## Test plan
- **Core read, zero-wait:** c_req, addr 0x100, m_ack at T+1, m_rdata 0xDEADBEEF. Expect c_gnt at T, c_rvalid at T+2, c_rdata 0xDEADBEEF, c_err 0.
- **Debug write, 3-wait:** d_req, we=1, addr 0x20, wdata 0x1234. Expect m_req high at T+1…T+4 with fields stable, ack at T+4, d_rvalid at T+5, d_rdata 0.
- **Simultaneous requests from reset:** both requests held continuously. Expect grants core, debug, core, debug, each exactly once per transaction, with no gnt during BUSY.
- **Timeout (TIMEOUT=16), no m_ack:** expect m_req low after T+16, c_rvalid and c_err at T+17. Repeat with m_ack at T+16: err=0, normal data.
- **Reset asserted in BUSY:** all outputs 0 immediately, no rvalid after release, and the first contention goes to the core.
- **Stray m_ack in IDLE:** no rvalid, state unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Owner ids double as the round-robin "last granted" marker.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_t;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Counts BUSY cycles without a memory ack; flags the TIMEOUT-th such cycle.
// Cleared when a new transaction is granted.
module arb_timeout_cnt
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of stalled cycles already seen, so the current
    // stalled cycle is the TIMEOUT-th one when cnt reaches TIMEOUT-1.
    assign expire = en && (cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one variable-latency memory port
// between the core and the debug loader, with a per-transaction timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy
);

    state_t              state_q, state_d;
    port_t               owner_q, last_gnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                in_busy;
    logic                expire;
    logic                done;
    logic                grant;
    logic [DATA_W-1:0]   rd_val;

    assign in_busy = (state_q == BUSY);
    // An ack in the expiry cycle wins, since expire is only raised without ack.
    assign done    = in_busy && (m_ack || expire);
    assign grant   = c_gnt || d_gnt;
    assign rd_val  = (m_ack && !we_q) ? m_rdata : '0;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (grant),
        .en     (in_busy && !m_ack),
        .expire (expire)
    );

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (c_req && (!d_req || last_gnt_q == PORT_DBG)) begin
                    c_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
                if (c_gnt || d_gnt) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= PORT_CORE;
            last_gnt_q <= PORT_DBG;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q    <= c_gnt ? PORT_CORE : PORT_DBG;
                last_gnt_q <= c_gnt ? PORT_CORE : PORT_DBG;
                we_q       <= c_gnt ? c_we    : d_we;
                addr_q     <= c_gnt ? c_addr  : d_addr;
                wdata_q    <= c_gnt ? c_wdata : d_wdata;
            end
        end
    end

    // rdata/err only update with a completion to the same port, else hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            c_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            c_rvalid <= done && (owner_q == PORT_CORE);
            d_rvalid <= done && (owner_q == PORT_DBG);
            if (done && owner_q == PORT_CORE) begin
                c_rdata <= rd_val;
                c_err   <= !m_ack;
            end
            if (done && owner_q == PORT_DBG) begin
                d_rdata <= rd_val;
                d_err   <= !m_ack;
            end
        end
    end

    // Memory-side outputs derive from the state register, so an async reset
    // drops m_req immediately.
    assign busy    = in_busy;
    assign m_req   = in_busy;
    assign m_we    = in_busy && we_q;
    assign m_addr  = in_busy ? addr_q  : '0;
    assign m_wdata = in_busy ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT = 16).
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic          c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          m_req, m_we, m_ack = 0, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; c_req = 0; d_req = 0; m_ack = 0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [2*DW+AW+DW+9-1:0] all_out;
        rstn = 1'b0;
        settle();
        all_out = {c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, m_req, m_we, busy,
                   c_rdata, d_rdata, m_addr, m_wdata};
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_core_read();
        c_req = 1; c_we = 0; c_addr = 32'h100; settle();
        total++;
        if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            bad++; $display("FAIL core_read_gnt: got c=%b d=%b want c=1 d=0", c_gnt, d_gnt);
        end
        tick();
        c_req = 0; c_addr = 32'h0; m_ack = 1; m_rdata = 32'hDEADBEEF; settle();
        total++;
        if ({m_req, m_we, busy, c_gnt, c_rvalid} !== 5'b10100 || m_addr !== 32'h100) begin
            bad++; $display("FAIL core_read_busy: got req/we/busy/gnt/rv=%b addr=%h want 10100 addr=100",
                            {m_req, m_we, busy, c_gnt, c_rvalid}, m_addr);
        end
        tick();
        m_ack = 0; m_rdata = '0; settle();
        total++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF || c_err !== 1'b0 || d_rvalid !== 1'b0
            || m_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL core_read_done: got rv=%b rdata=%h err=%b drv=%b mreq=%b busy=%b want 1 deadbeef 0 0 0 0",
                            c_rvalid, c_rdata, c_err, d_rvalid, m_req, busy);
        end
        tick();
        total++;
        if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL core_read_hold: got rv=%b rdata=%h want 0 deadbeef", c_rvalid, c_rdata);
        end
    endtask

    task automatic test_dbg_write_wait();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234; settle();
        total++;
        if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin
            bad++; $display("FAIL dbg_write_gnt: got d=%b c=%b want d=1 c=0", d_gnt, c_gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            d_req = 0; d_we = 0; d_addr = 32'hFFFF_0000 + k; d_wdata = 32'h0BAD_0000 + k;
            if (k == 4) begin
                m_ack = 1; m_rdata = 32'hFFFF_FFFF;
            end
            settle();
            total++;
            if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h20 || m_wdata !== 32'h1234 || d_rvalid !== 1'b0) begin
                bad++; $display("FAIL dbg_write_hold_T%0d: got req=%b we=%b addr=%h wdata=%h drv=%b want 1 1 20 1234 0",
                                k, m_req, m_we, m_addr, m_wdata, d_rvalid);
            end
        end
        tick();
        m_ack = 0; m_rdata = '0; settle();
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0 || c_rvalid !== 1'b0 || m_req !== 1'b0) begin
            bad++; $display("FAIL dbg_write_done: got drv=%b rdata=%h err=%b crv=%b mreq=%b want 1 0 0 0 0",
                            d_rvalid, d_rdata, d_err, c_rvalid, m_req);
        end
        tick();
    endtask

    task automatic test_stray_ack();
        m_ack = 1; m_rdata = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({c_rvalid, d_rvalid, m_req, busy} !== 4'b0000 || c_rdata !== 32'hDEADBEEF) begin
                bad++; $display("FAIL stray_ack_%0d: got crv/drv/mreq/busy=%b crdata=%h want 0000 deadbeef",
                                k, {c_rvalid, d_rvalid, m_req, busy}, c_rdata);
            end
        end
        m_ack = 0; m_rdata = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_core;
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h80;
        settle();
        for (int i = 0; i < 4; i++) begin
            exp_core = (i % 2 == 0);
            total++;
            if (c_gnt !== exp_core || d_gnt !== !exp_core) begin
                bad++; $display("FAIL rr_gnt_%0d: got c=%b d=%b want c=%b d=%b", i, c_gnt, d_gnt, exp_core, !exp_core);
            end
            if (i > 0) begin
                total++;
                if (c_rvalid !== !exp_core || d_rvalid !== exp_core || m_req !== 1'b0) begin
                    bad++; $display("FAIL rr_rvalid_%0d: got crv=%b drv=%b mreq=%b want %b %b 0",
                                    i, c_rvalid, d_rvalid, m_req, !exp_core, exp_core);
                end
            end
            tick();
            m_ack = 1; m_rdata = 32'h55 + i; settle();
            total++;
            if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || m_req !== 1'b1 || m_addr !== (exp_core ? 32'h40 : 32'h80)) begin
                bad++; $display("FAIL rr_busy_%0d: got cg=%b dg=%b mreq=%b addr=%h want 0 0 1 %h",
                                i, c_gnt, d_gnt, m_req, m_addr, exp_core ? 32'h40 : 32'h80);
            end
            tick();
            m_ack = 0; settle();
        end
        c_req = 0; d_req = 0;
        total++;
        if (c_rvalid !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'h58 || c_rdata !== 32'h57) begin
            bad++; $display("FAIL rr_last: got crv=%b drv=%b drdata=%h crdata=%h want 0 1 58 57",
                            c_rvalid, d_rvalid, d_rdata, c_rdata);
        end
        tick();
    endtask

    task automatic run_timeout(input logic ack_last, input string tag);
        c_req = 1; c_we = 0; c_addr = 32'h300; settle();
        total++;
        if (c_gnt !== 1'b1) begin
            bad++; $display("FAIL %s_gnt: got %b want 1", tag, c_gnt);
        end
        for (int k = 1; k <= TO; k++) begin
            tick();
            c_req = 0;
            if (k == TO && ack_last) begin
                m_ack = 1; m_rdata = 32'hCAFEF00D;
            end
            settle();
            total++;
            if (m_req !== 1'b1 || c_rvalid !== 1'b0) begin
                bad++; $display("FAIL %s_wait_T%0d: got mreq=%b rv=%b want 1 0", tag, k, m_req, c_rvalid);
            end
        end
        tick();
        m_ack = 0; m_rdata = '0; settle();
        total++;
        if (m_req !== 1'b0 || busy !== 1'b0 || c_rvalid !== 1'b1 || c_err !== !ack_last
            || c_rdata !== (ack_last ? 32'hCAFEF00D : 32'h0)) begin
            bad++; $display("FAIL %s_end: got mreq=%b busy=%b rv=%b err=%b rdata=%h want 0 0 1 %b %h",
                            tag, m_req, busy, c_rvalid, c_err, c_rdata, !ack_last,
                            ack_last ? 32'hCAFEF00D : 32'h0);
        end
        tick();
    endtask

    task automatic test_timeout();
        run_timeout(1'b0, "timeout_noack");
        run_timeout(1'b1, "timeout_lastack");
    endtask

    task automatic test_reset_in_busy();
        c_req = 1; c_we = 1; c_addr = 32'h500; c_wdata = 32'hA5A5; settle();
        tick();
        c_req = 0; settle();
        total++;
        if (m_req !== 1'b1) begin
            bad++; $display("FAIL rib_busy: got mreq=%b want 1", m_req);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({m_req, m_we, busy, c_rvalid, c_err, d_rvalid, d_err, c_gnt, d_gnt} !== 9'b0
            || m_addr !== '0 || m_wdata !== '0 || c_rdata !== '0 || d_rdata !== '0) begin
            bad++; $display("FAIL rib_async: got flags=%b addr=%h wdata=%h crdata=%h drdata=%h want all 0",
                            {m_req, m_we, busy, c_rvalid, c_err, d_rvalid, d_err, c_gnt, d_gnt},
                            m_addr, m_wdata, c_rdata, d_rdata);
        end
        m_ack = 1;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_req !== 1'b0) begin
                bad++; $display("FAIL rib_no_rvalid_%0d: got crv=%b drv=%b mreq=%b want 0 0 0",
                                k, c_rvalid, d_rvalid, m_req);
            end
        end
        m_ack = 0;
        c_req = 1; d_req = 1; c_we = 0; d_we = 0; settle();
        total++;
        if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            bad++; $display("FAIL rib_first_contention: got c=%b d=%b want c=1 d=0", c_gnt, d_gnt);
        end
        tick();
        c_req = 0; d_req = 0; m_ack = 1;
        tick();
        m_ack = 0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_core_read();
        test_dbg_write_wait();
        test_stray_ack();
        test_back_to_back();
        test_timeout();
        test_reset_in_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
